// File: rtl/magnitude_to_a2_complement_converter_pkg.sv
// Shared definitions for the multi-cycle sign/magnitude units: common FSM
// state type and default datapath widths.
package magnitude_to_a2_complement_converter_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_CHUNK_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } mc_state_t;

endpackage

// File: rtl/magnitude_to_a2_complement_converter_chunk_negate_unit.sv
// One chunk of a ripple negation: out = ~chunk + carry_in when negating,
// pass-through otherwise. Carry-out feeds the next (more significant) chunk.
module chunk_negate_unit #(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] i_chunk,
    input  logic                   i_negate,
    input  logic                   i_carry_in,
    output logic [CHUNK_WIDTH-1:0] o_chunk_out,
    output logic                   o_carry_out
);

    logic [CHUNK_WIDTH:0] w_inv_sum;

    assign w_inv_sum   = {1'b0, ~i_chunk} + {{CHUNK_WIDTH{1'b0}}, i_carry_in};
    assign o_chunk_out = i_negate ? w_inv_sum[CHUNK_WIDTH-1:0] : i_chunk;
    assign o_carry_out = i_negate & w_inv_sum[CHUNK_WIDTH];

endmodule

// File: rtl/magnitude_to_a2_complement_converter.sv
// Chunk-serial sign-magnitude to two's-complement converter with overflow
// detection. Define SATURATION_EN to clamp overflowing results.
module magnitude_to_a2_complement_converter
    import magnitude_to_a2_complement_converter_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] In_Magnitude,
    input  logic                  In_Sign,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow
);

    localparam int N_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    generate
        if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || DATA_WIDTH < 2) begin : g_bad_width
            $error("DATA_WIDTH must be >= 2 and a multiple of CHUNK_WIDTH");
        end
    endgenerate

    mc_state_t r_state, w_state_next;

    logic [DATA_WIDTH-1:0]  r_mag;
    logic                   r_sign;
    logic                   r_ovf;
    logic                   r_carry;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_WIDTH-1:0]  r_work;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_overflow;

    logic [CHUNK_WIDTH-1:0] w_chunk_in;
    logic [CHUNK_WIDTH-1:0] w_chunk_out;
    logic                   w_carry_out;
    logic [DATA_WIDTH-1:0]  w_work_next;
    logic [DATA_WIDTH-1:0]  w_result_next;
    logic                   w_ovf_in;
    logic                   w_last;

    // -2^(W-1) is representable, so a negative input only overflows beyond it
    assign w_ovf_in = In_Sign ? (In_Magnitude[DATA_WIDTH-1] & (|In_Magnitude[DATA_WIDTH-2:0]))
                              :  In_Magnitude[DATA_WIDTH-1];

    assign w_last     = (r_state == CONVERT) && (r_idx == LAST_IDX);
    assign w_chunk_in = r_mag[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH];

    chunk_negate_unit #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunk_negate (
        .i_chunk     (w_chunk_in),
        .i_negate    (r_sign),
        .i_carry_in  (r_carry),
        .o_chunk_out (w_chunk_out),
        .o_carry_out (w_carry_out)
    );

    always_comb begin
        w_work_next = r_work;
        w_work_next[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH] = w_chunk_out;
    end

`ifdef SATURATION_EN
    always_comb begin
        w_result_next = w_work_next;
        if (r_ovf)
            w_result_next = r_sign ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    assign w_result_next = w_work_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_state_next = CONVERT;
            CONVERT: if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy     = (r_state != IDLE);
        Done     = (r_state == DONE);
        Result   = r_result;
        Overflow = r_overflow;
    end

    // Result/Overflow only move on the final chunk, so partial work never leaks out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mag      <= '0;
            r_sign     <= 1'b0;
            r_ovf      <= 1'b0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_work     <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_mag   <= In_Magnitude;
                        r_sign  <= In_Sign;
                        r_ovf   <= w_ovf_in;
                        r_carry <= 1'b1;
                        r_idx   <= '0;
                        r_work  <= '0;
                    end
                end
                CONVERT: begin
                    r_work  <= w_work_next;
                    r_carry <= w_carry_out;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_result   <= w_result_next;
                        r_overflow <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_magnitude_to_a2_complement_converter.sv
// Randomized self-checking bench for the sign-magnitude converter, against an
// arithmetic reference model.
module tb_magnitude_to_a2_complement_converter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] In_Magnitude = '0;
    logic        In_Sign = 1'b0;
    logic        Busy, Done, Overflow;
    logic [31:0] Result;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    magnitude_to_a2_complement_converter dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .In_Magnitude (In_Magnitude),
        .In_Sign      (In_Sign),
        .Busy         (Busy),
        .Done         (Done),
        .Result       (Result),
        .Overflow     (Overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {overflow, result} from signed arithmetic on the magnitude
    function automatic logic [32:0] ref_model(input logic s, input logic [31:0] m);
        longint v;
        logic   ovf;
        logic [31:0] r;
        v   = s ? -longint'(m) : longint'(m);
        ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        r   = v[31:0];
`ifdef SATURATION_EN
        if (ovf) r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {ovf, r};
    endfunction

    task automatic do_req(input logic s, input logic [31:0] m, input string tag);
        int cyc;
        logic [32:0] e;
        e = ref_model(s, m);
        @(negedge clk);
        Start = 1'b1; In_Sign = s; In_Magnitude = m;
        @(negedge clk);
        Start = 1'b0; In_Sign = 1'($urandom); In_Magnitude = $urandom;
        chk({tag, "_busy"}, 64'(Busy), 64'd1);
        cyc = 1;
        while (!Done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd5);
        chk({tag, "_res"}, 64'(Result), 64'(e[31:0]));
        chk({tag, "_ovf"}, 64'(Overflow), 64'(e[32]));
        @(negedge clk);
        chk({tag, "_idle"}, {62'd0, Busy, Done}, 64'd0);
        chk({tag, "_hold"}, 64'(Result), 64'(e[31:0]));
    endtask

    initial begin
        logic [32:0] e;
        logic        s2;
        logic [31:0] m2;
        int          cyc, last_done, n_done, seen;

        repeat (3) @(negedge clk);
        chk("rst_out", {30'd0, Busy, Done, Overflow, 1'b0, Result}, 64'd0);
        reset = 1'b1;

        do_req(1'b1, 32'd5,          "neg5");
        do_req(1'b0, 32'h7FFF_FFFF,  "posmax");
        do_req(1'b1, 32'h8000_0000,  "negmin");
        do_req(1'b1, 32'd0,          "negzero");
        do_req(1'b0, 32'h8000_0000,  "posovf");
        do_req(1'b1, 32'h8000_0001,  "negovf");
        do_req(1'b0, 32'd0,          "poszero");

        // Start re-asserted mid-conversion must be ignored
        e = ref_model(1'b1, 32'h1234_5678);
        @(negedge clk);
        Start = 1'b1; In_Sign = 1'b1; In_Magnitude = 32'h1234_5678;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        Start = 1'b1; In_Sign = 1'b0; In_Magnitude = 32'hDEAD_BEEF;
        @(negedge clk);
        Start = 1'b0;
        cyc = 3;
        while (!Done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_lat", 64'(cyc), 64'd5);
        chk("ign_res", 64'(Result), 64'(e[31:0]));
        @(negedge clk);

        // Start held high: one Done every 6 cycles, new data per request
        s2 = 1'b1; m2 = 32'd77;
        e = ref_model(s2, m2);
        Start = 1'b1; In_Sign = s2; In_Magnitude = m2;
        last_done = -1; n_done = 0;
        for (int c = 0; c < 40 && n_done < 4; c++) begin
            @(negedge clk);
            if (Done) begin
                chk("held_res", 64'(Result), 64'(e[31:0]));
                chk("held_ovf", 64'(Overflow), 64'(e[32]));
                if (last_done >= 0) chk("held_period", 64'(c - last_done), 64'd6);
                last_done = c;
                n_done++;
                s2 = 1'($urandom); m2 = $urandom;
                e = ref_model(s2, m2);
                In_Sign = s2; In_Magnitude = m2;
            end
        end
        chk("held_count", 64'(n_done), 64'd4);
        Start = 1'b0;
        repeat (8) @(negedge clk);

        // Reset during the 2nd CONVERT cycle aborts the request
        @(negedge clk);
        Start = 1'b1; In_Sign = 1'b1; In_Magnitude = 32'd9;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_out", {30'd0, Busy, Done, Overflow, 1'b0, Result}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (Done || Busy) seen++;
        end
        chk("abort_nodone", 64'(seen), 64'd0);
        do_req(1'b1, 32'd300, "post_abort");

        // Random requests, biased toward the boundary magnitudes
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 4))
                0:       m2 = 32'h8000_0000;
                1:       m2 = 32'h8000_0000 | $urandom_range(0, 3);
                2:       m2 = $urandom_range(0, 255);
                default: m2 = $urandom;
            endcase
            do_req(1'($urandom), m2, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
